// File: rtl/fifo_packetizer.sv
// Frames show-ahead FIFO words into header / payload / checksum-trailer packets
// on a valid/ready stream, padding a starved packet out after a timeout.
module fifo_packetizer #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    PKT_WORDS  = 256,
  parameter int                    TIMEOUT    = 1024,
  parameter logic [7:0]            HDR_TAG    = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rdreq,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  pad_pulse,
  output logic [7:0]            seq
);

  localparam int WC_W  = $clog2(PKT_WORDS + 1);
  localparam int TC_W  = $clog2(TIMEOUT + 1);
  localparam int SEQ_W = DATA_WIDTH - 8;

  typedef enum logic [1:0] {IDLE, PAYLOAD, PAD, TRAILER} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] data_r, data_nxt;
  logic                  valid_r, valid_nxt;
  logic                  last_r, last_nxt;
  logic                  pad_r, pad_nxt;
  logic [7:0]            seq_r, seq_nxt;
  logic [WC_W-1:0]       word_cnt, word_cnt_nxt;
  logic [TC_W-1:0]       tmo_cnt, tmo_cnt_nxt;
  logic [DATA_WIDTH-1:0] csum, csum_nxt;
  logic                  rdreq;
  logic                  load_en;
  logic [DATA_WIDTH-1:0] header;

  assign load_en = ~valid_r | out_ready;
  assign header  = {HDR_TAG, SEQ_W'(seq_r)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_r   <= '0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      pad_r    <= 1'b0;
      seq_r    <= '0;
      word_cnt <= '0;
      tmo_cnt  <= '0;
      csum     <= '0;
    end else begin
      state    <= state_nxt;
      data_r   <= data_nxt;
      valid_r  <= valid_nxt;
      last_r   <= last_nxt;
      pad_r    <= pad_nxt;
      seq_r    <= seq_nxt;
      word_cnt <= word_cnt_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      csum     <= csum_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    data_nxt     = data_r;
    valid_nxt    = valid_r;
    last_nxt     = last_r;
    pad_nxt      = 1'b0;
    seq_nxt      = seq_r;
    word_cnt_nxt = word_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    csum_nxt     = csum;
    rdreq        = 1'b0;

    // Every branch that sees load_en either loads a word or drops out_valid,
    // so nothing changes on the stream while the consumer stalls.
    case (state)
      IDLE: begin
        if (enable && !fifo_empty && load_en) begin
          data_nxt     = header;
          valid_nxt    = 1'b1;
          last_nxt     = 1'b0;
          csum_nxt     = header;
          word_cnt_nxt = '0;
          tmo_cnt_nxt  = '0;
          state_nxt    = PAYLOAD;
        end else if (load_en) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
        end
      end
      PAYLOAD: begin
        if (load_en) begin
          last_nxt = 1'b0;
          if (!fifo_empty) begin
            rdreq        = 1'b1;
            data_nxt     = fifo_q;
            valid_nxt    = 1'b1;
            csum_nxt     = csum ^ fifo_q;
            word_cnt_nxt = word_cnt + WC_W'(1);
            tmo_cnt_nxt  = '0;
            if (word_cnt == WC_W'(PKT_WORDS - 1)) state_nxt = TRAILER;
          end else begin
            valid_nxt = 1'b0;
            if (tmo_cnt == TC_W'(TIMEOUT - 1)) begin
              tmo_cnt_nxt = '0;
              pad_nxt     = 1'b1;
              state_nxt   = PAD;
            end else begin
              tmo_cnt_nxt = tmo_cnt + TC_W'(1);
            end
          end
        end
      end
      PAD: begin
        if (load_en) begin
          data_nxt     = PAD_WORD;
          valid_nxt    = 1'b1;
          last_nxt     = 1'b0;
          csum_nxt     = csum ^ PAD_WORD;
          word_cnt_nxt = word_cnt + WC_W'(1);
          if (word_cnt == WC_W'(PKT_WORDS - 1)) state_nxt = TRAILER;
        end
      end
      TRAILER: begin
        if (load_en) begin
          data_nxt     = csum;
          valid_nxt    = 1'b1;
          last_nxt     = 1'b1;
          seq_nxt      = seq_r + 8'd1;
          word_cnt_nxt = '0;
          tmo_cnt_nxt  = '0;
          csum_nxt     = '0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rdreq = rdreq;
  assign out_data   = data_r;
  assign out_valid  = valid_r;
  assign out_last   = last_r;
  assign pad_pulse  = pad_r;
  assign seq        = seq_r;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_packetizer.sv
// Randomized and directed bench for fifo_packetizer: a queue-based FIFO model
// feeds the DUT and a packet-grammar scoreboard checks the output stream.
module tb_fifo_packetizer;

  localparam int          DW      = 16;
  localparam int          PKT     = 4;
  localparam int          TMO     = 8;
  localparam logic [15:0] PADW    = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic          fifo_rdreq;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          pad_pulse;
  logic [7:0]    seq;

  fifo_packetizer #(
    .DATA_WIDTH(DW),
    .PKT_WORDS (PKT),
    .TIMEOUT   (TMO),
    .HDR_TAG   (8'hA5),
    .PAD_WORD  (PADW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_q    (fifo_q),
    .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .pad_pulse (pad_pulse),
    .seq       (seq)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] fq[$];
  logic [15:0] sent[$];
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  int          cyc = 0;
  int          ready_mode = 0;
  bit          feed_en = 0;
  bit          pop_pending = 0;
  int          pops = 0;
  int          rdreq_cnt = 0;
  int          last_pop_cyc = 0;
  int          pad_cyc = -1;
  bit          hold_prev = 0;
  logic [15:0] prev_data;
  logic        prev_last;

  int          idx = 0;
  bit          padding = 0;
  int          pad_in_pkt = 0;
  logic [15:0] acc;
  logic [7:0]  exp_seq = 0;
  int          pkts = 0;
  logic [15:0] hdr257 = 16'hxxxx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fq.size() == 0);
    fifo_q     = (fq.size() != 0) ? fq[0] : 16'h0000;
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    sent.push_back(w);
    fifo_sync();
  endtask

  task automatic model_reset();
    fq.delete();
    sent.delete();
    log_q.delete();
    fifo_sync();
    pop_pending = 0;
    hold_prev   = 0;
    idx         = 0;
    padding     = 0;
    pad_in_pkt  = 0;
    exp_seq     = 0;
    pkts        = 0;
    pad_cyc     = -1;
  endtask

  // Packet grammar: header {A5,seq}, PKT payload slots filled in FIFO order
  // until padding starts, then pads only, then XOR trailer with last=1.
  task automatic score(input logic [15:0] d, input logic l);
    logic [15:0] e;
    log_q.push_back(d);
    if (idx == 0) begin
      check_eq("header", d, {8'hA5, exp_seq});
      check_eq("last_on_header", l, 0);
      if (pkts == 256) hdr257 = d;
      acc     = d;
      padding = 0;
      idx     = 1;
    end else if (idx <= PKT) begin
      if (padding) begin
        check_eq("pad_word", d, PADW);
      end else if (d == PADW) begin
        padding = 1;
      end else begin
        e = (sent.size() != 0) ? sent.pop_front() : PADW;
        check_eq("payload", d, e);
      end
      check_eq("last_on_payload", l, 0);
      acc = acc ^ d;
      idx++;
    end else begin
      check_eq("trailer", d, acc);
      check_eq("last_on_trailer", l, 1);
      check_eq("pad_pulse_count", pad_in_pkt, padding ? 1 : 0);
      exp_seq++;
      pkts++;
      idx        = 0;
      pad_in_pkt = 0;
    end
  endtask

  // One clock, entered and left at a negedge; outputs sampled 1 time unit
  // before the posedge, FIFO pops applied on the following negedge.
  task automatic tick();
    if (pop_pending) begin
      if (fq.size() != 0) void'(fq.pop_front());
      pop_pending = 0;
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (feed_en && fq.size() < 12 && $urandom_range(0, 9) < 6)
      push(16'($urandom_range(1, 16'hFFFF)));
    fifo_sync();
    #4;
    cyc++;
    if (hold_prev) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", out_data, prev_data);
      check_eq("hold_last", out_last, prev_last);
    end
    hold_prev = out_valid & ~out_ready;
    prev_data = out_data;
    prev_last = out_last;
    if (out_valid && out_ready) score(out_data, out_last);
    if (pad_pulse) begin
      pad_in_pkt++;
      pad_cyc = cyc;
    end
    if (fifo_rdreq) begin
      check_eq("rdreq_when_empty", fifo_empty, 0);
      check_eq("rdreq_when_idle", busy, 1);
      pop_pending  = 1;
      pops++;
      rdreq_cnt++;
      last_pop_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts < target && n < budget) begin
      tick();
      n++;
    end
    check_eq("packets_done_in_time", (pkts >= target), 1);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), (i < log_q.size()) ? log_q[i] : 16'hxxxx, exp_q[i]);
  endtask

  task automatic do_reset(input bit chk);
    #2 rst_n = 1'b0;
    #1;
    if (chk) begin
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_seq", seq, 0);
    end
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #3;
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_last", out_last, 0);
    check_eq("reset_out_data", out_data, 0);
    check_eq("reset_seq", seq, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_pad_pulse", pad_pulse, 0);
    check_eq("reset_rdreq", fifo_rdreq, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic packet from a preloaded FIFO.
    for (int i = 1; i <= 4; i++) push(16'(i));
    enable = 1'b1;
    wait_pkts(1, 60);
    exp_q = {16'hA500, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hA504};
    check_log("pktA");
    check_eq("seq_after_pktA", seq, 1);
    check_eq("busy_after_pktA", busy, 0);

    // Same payload under 1-0-1 backpressure.
    log_q.delete();
    p0 = pops;
    ready_mode = 1;
    for (int i = 1; i <= 4; i++) push(16'(i));
    wait_pkts(2, 80);
    exp_q = {16'hA501, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hA505};
    check_log("pktB");
    check_eq("pops_pktB", pops - p0, 4);
    ready_mode = 0;

    // Starvation: two words, then padding; refill during padding is not read.
    do_reset(0);
    push(16'h0011);
    push(16'h0022);
    begin
      int n = 0;
      while (pad_cyc < 0 && n < 100) begin tick(); n++; end
    end
    check_eq("pad_pulse_seen", (pad_cyc >= 0), 1);
    check_eq("starved_cycles", pad_cyc - last_pop_cyc - 1, TMO);
    push(16'h0033); push(16'h0044); push(16'h0055); push(16'h0066);
    wait_pkts(2, 100);
    exp_q = {16'hA500, 16'h0011, 16'h0022, 16'h0000, 16'h0000, 16'hA533,
             16'hA501, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'hA545};
    check_log("pktC");

    // Asynchronous reset mid-payload after two pops.
    check_eq("seq_before_rst", seq, 2);
    p0 = pops;
    push(16'h0A0A);
    push(16'h0B0B);
    begin
      int n = 0;
      while (pops < p0 + 2 && n < 30) begin tick(); n++; end
    end
    check_eq("busy_mid_payload", busy, 1);
    do_reset(1);
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    wait_pkts(1, 60);
    check_eq("hdr_after_rst", (log_q.size() != 0) ? log_q[0] : 16'hxxxx, 16'hA500);

    // enable dropped mid-packet: packet completes, then no further reads.
    p0 = pops;
    push(16'h0101);
    push(16'h0202);
    begin
      int n = 0;
      while (pops < p0 + 1 && n < 30) begin tick(); n++; end
    end
    enable = 1'b0;
    push(16'h0303);
    push(16'h0404);
    wait_pkts(2, 60);
    push(16'h0505); push(16'h0606); push(16'h0707); push(16'h0808);
    rdreq_cnt = 0;
    repeat (20) tick();
    check_eq("rdreq_while_disabled", rdreq_cnt, 0);
    check_eq("busy_while_disabled", busy, 0);
    check_eq("fifo_left_untouched", fq.size(), 4);
    check_eq("valid_while_disabled", out_valid, 0);

    // Long random run across the sequence-number wrap.
    do_reset(0);
    ready_mode = 2;
    feed_en    = 1;
    enable     = 1'b1;
    wait_pkts(257, 20000);
    check_eq("hdr_packet_257", hdr257, 16'hA500);
    feed_en = 0;
    enable  = 1'b0;
    repeat (60) tick();
    check_eq("idle_at_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
